// File: rtl/fpu_pkg.sv
// Shared constants, operand classes and field helpers for the single-precision
// add post-processing stage.
`timescale 1ns/1ps
package fpu_pkg;

    localparam logic [7:0]  EXP_MAX      = 8'hFF;
    localparam logic [31:0] QNAN         = 32'h7FC00000;
    localparam logic [31:0] INF_POS      = 32'h7F800000;
    localparam int          FLAG_INVALID = 2;
    localparam int          FLAG_OVF     = 1;
    localparam int          FLAG_ZERO    = 0;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } fp_class_e;

    function automatic logic [7:0] fp_exp(input logic [31:0] v);
        return v[30:23];
    endfunction

    function automatic logic [22:0] fp_mant(input logic [31:0] v);
        return v[22:0];
    endfunction

    // Denormals (exponent 00) are classed as zero: they are flushed.
    function automatic fp_class_e fp_classify(input logic [31:0] v);
        fp_class_e c;
        if (fp_exp(v) == EXP_MAX) begin
            c = (fp_mant(v) != 23'd0) ? NAN : INF;
        end else if (fp_exp(v) == 8'd0) begin
            c = ZERO;
        end else begin
            c = NORMAL;
        end
        return c;
    endfunction

endpackage

// File: rtl/fp_res_fifo.sv
// Two-entry result FIFO with occupancy count; a push is refused when full,
// even if a pop happens in the same cycle.
`timescale 1ns/1ps
module fp_res_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    logic [WIDTH-1:0] mem_r [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == 2'd0);
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign pop_data  = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage and write pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wr_ptr_r <= 1'b0;
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= ~wr_ptr_r;
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Read pointer and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (do_pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fp_add_post.sv
// Post-processing for the combinational single-precision adder: patches special
// operands, overflow and result sign, then buffers {flags, result} in a FIFO.
`timescale 1ns/1ps
module fp_add_post
    import fpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        op_ctrl,
    output logic        add_en,
    input  logic [31:0] add_ans,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_res,
    output logic [2:0]  out_flags
);

    fp_class_e   cls_a_s;
    fp_class_e   cls_b_s;
    logic        bs_s;
    logic        sign_s;
    logic [31:0] res_s;
    logic        inv_s;
    logic        ovf_s;
    logic [2:0]  flags_s;
    logic [34:0] head_s;
    logic [1:0]  count_s;
    logic        full_s;
    logic        empty_s;
    logic        push_s;

    assign bs_s    = op_b[31] ^ op_ctrl;
    assign cls_a_s = fp_classify(op_a);
    assign cls_b_s = fp_classify(op_b);
    // Larger magnitude wins the sign; on a tie the (effective) b sign is kept.
    assign sign_s  = (op_a[30:0] > op_b[30:0]) ? op_a[31] : bs_s;
    assign add_en  = in_valid;

    // Special-case fix-up, first match wins
    always_comb begin
        res_s = add_ans;
        inv_s = 1'b0;
        ovf_s = 1'b0;
        if (cls_a_s == NAN || cls_b_s == NAN) begin
            res_s = QNAN;
            inv_s = 1'b1;
        end else if (cls_a_s == INF && cls_b_s == INF && op_a[31] != bs_s) begin
            res_s = QNAN;
            inv_s = 1'b1;
        end else if (cls_a_s == INF) begin
            res_s = {op_a[31], INF_POS[30:0]};
        end else if (cls_b_s == INF) begin
            res_s = {bs_s, INF_POS[30:0]};
        end else if (cls_a_s == ZERO && cls_b_s == ZERO) begin
            res_s = {op_a[31] & bs_s, 31'd0};
        end else if (cls_a_s == ZERO) begin
            res_s = {bs_s, op_b[30:0]};
        end else if (cls_b_s == ZERO) begin
            res_s = op_a;
        end else if (add_ans[30:23] == EXP_MAX) begin
            res_s = {sign_s, INF_POS[30:0]};
            ovf_s = 1'b1;
        end else if (add_ans[30:0] == 31'd0) begin
            res_s = 32'd0;
        end else begin
            res_s = {sign_s, add_ans[30:0]};
        end
    end

    // Flag vector assembly
    always_comb begin
        flags_s               = 3'b000;
        flags_s[FLAG_INVALID] = inv_s;
        flags_s[FLAG_OVF]     = ovf_s;
        flags_s[FLAG_ZERO]    = (res_s[30:0] == 31'd0);
    end

    assign in_ready = (count_s != 2'd2);
    assign push_s   = in_valid & ~full_s;

    fp_res_fifo #(
        .WIDTH (35),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data ({flags_s, res_s}),
        .pop       (out_ready),
        .pop_data  (head_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign out_valid = ~empty_s;
    assign out_res   = head_s[31:0];
    assign out_flags = head_s[34:32];

endmodule

// File: tb/tb_fp_add_post.sv
// Self-checking bench for fp_add_post: directed vectors, randomized operands
// against a rule-level reference model, backpressure and async reset sequences.
`timescale 1ns/1ps
module tb_fp_add_post;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_ctrl;
    logic        add_en;
    logic [31:0] add_ans;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic [2:0]  out_flags;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_add_post #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_ctrl   (op_ctrl),
        .add_en    (add_en),
        .add_ans   (add_ans),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_flags (out_flags)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ctrl;
        logic [31:0] ans;
        logic [31:0] res;
        logic [2:0]  flags;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: IEEE-style classification and magnitude comparison done with plain arithmetic.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic ctrl, input logic [31:0] ans);
        int unsigned ea, eb, ma, mb, mag_a, mag_b, mag_r;
        bit sa, sb, a_nan, b_nan, a_inf, b_inf, a_z, b_z, inv, ovf, s;
        logic [31:0] r;
        ea = (a >> 23) & 32'hFF;  eb = (b >> 23) & 32'hFF;
        ma = a & 32'h7FFFFF;      mb = b & 32'h7FFFFF;
        mag_a = a & 32'h7FFFFFFF; mag_b = b & 32'h7FFFFFFF;
        mag_r = ans & 32'h7FFFFFFF;
        sa = a[31];               sb = b[31] ^ ctrl;
        a_nan = (ea == 255) && (ma != 0);  b_nan = (eb == 255) && (mb != 0);
        a_inf = (ea == 255) && (ma == 0);  b_inf = (eb == 255) && (mb == 0);
        a_z = (ea == 0);          b_z = (eb == 0);
        inv = 0; ovf = 0;
        s = (mag_a > mag_b) ? sa : sb;
        if (a_nan || b_nan) begin r = 32'h7FC00000; inv = 1; end
        else if (a_inf && b_inf && sa != sb) begin r = 32'h7FC00000; inv = 1; end
        else if (a_inf) r = 32'h7F800000 | (32'(sa) << 31);
        else if (b_inf) r = 32'h7F800000 | (32'(sb) << 31);
        else if (a_z && b_z) r = 32'(sa && sb) << 31;
        else if (a_z) r = mag_b | (32'(sb) << 31);
        else if (b_z) r = a;
        else if (((ans >> 23) & 32'hFF) == 255) begin r = 32'h7F800000 | (32'(s) << 31); ovf = 1; end
        else if (mag_r == 0) r = 32'd0;
        else r = mag_r | (32'(s) << 31);
        return {inv, ovf, (r & 32'h7FFFFFFF) == 0, r};
    endfunction

    // One isolated transaction with out_ready high: checks latency, result, flags.
    task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic c, input logic [31:0] ans,
                           input logic [31:0] er, input logic [2:0] ef);
        @(negedge clk);
        op_a = a; op_b = b; op_ctrl = c; add_ans = ans;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({name, " add_en"}, 32'(add_en), 32'd1);
        check({name, " pre-valid"}, 32'(out_valid), 32'd0);
        check({name, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({name, " out_valid"}, 32'(out_valid), 32'd1);
        check({name, " res"}, out_res, er);
        check({name, " flags"}, 32'(out_flags), 32'(ef));
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] a, b, ans;
        logic        c;
        logic [34:0] m;
        logic [31:0] got[$];
        logic [31:0] want[3];
        logic        acc;

        vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 32'h40400000, 3'b000};
        vecs[1]  = '{32'h3F800000, 32'h40000000, 1'b1, 32'h3F800000, 32'hBF800000, 3'b000};
        vecs[2]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 32'h00000000, 3'b001};
        vecs[3]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7F800000, 32'h7FC00000, 3'b100};
        vecs[4]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00001, 32'h7FC00000, 3'b100};
        vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7FFFFFFE, 32'h7F800000, 3'b010};
        vecs[6]  = '{32'h00000000, 32'h40000000, 1'b1, 32'hC0000000, 32'hC0000000, 3'b000};
        vecs[7]  = '{32'h80000000, 32'h00000000, 1'b1, 32'h00000000, 32'h80000000, 3'b001};
        vecs[8]  = '{32'h00000001, 32'h40000000, 1'b0, 32'h40000000, 32'h40000000, 3'b000};
        vecs[9]  = '{32'h40400000, 32'h00000005, 1'b0, 32'h40400000, 32'h40400000, 3'b000};
        vecs[10] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 32'hFF800000, 3'b000};
        vecs[11] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 32'h00000000, 3'b001};
        vecs[12] = '{32'hC0000000, 32'h40000000, 1'b1, 32'h40800000, 32'hC0800000, 3'b000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = 32'd0; op_b = 32'd0; op_ctrl = 1'b0; add_ans = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_res", out_res, 32'd0);
        check("rst out_flags", 32'(out_flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ctrl,
                    vecs[i].ans, vecs[i].res, vecs[i].flags);
        end

        for (int i = 0; i < 150; i++) begin
            a = $urandom(); b = $urandom(); ans = $urandom(); c = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: a[30:23] = 8'h00;
                1: begin a[30:23] = 8'hFF; a[22:0] = 23'd0; end
                2: a[30:23] = 8'hFF;
                default: ;
            endcase
            case ($urandom_range(0, 5))
                0: b[30:23] = 8'h00;
                1: begin b[30:23] = 8'hFF; b[22:0] = 23'd0; end
                2: b = {a[31], a[30:0]};
                default: ;
            endcase
            case ($urandom_range(0, 4))
                0: ans[30:23] = 8'hFF;
                1: ans[30:0] = 31'd0;
                default: ;
            endcase
            m = model(a, b, c, ans);
            run_one($sformatf("rand%0d", i), a, b, c, ans, m[31:0], m[34:32]);
        end

        // Backpressure: two accepts fill the buffer, third request is held.
        want[0] = 32'h40400000; want[1] = 32'hC0000000; want[2] = 32'h7F800000;
        @(negedge clk);
        out_ready = 1'b0;
        op_a = 32'h3F800000; op_b = 32'h40000000; op_ctrl = 1'b0; add_ans = 32'h40400000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("bp in_ready after 1", 32'(in_ready), 32'd1);
        check("bp head after 1", out_res, want[0]);
        op_a = 32'h00000000; op_b = 32'h40000000; op_ctrl = 1'b1; add_ans = 32'hC0000000;
        @(posedge clk); #1;
        check("bp in_ready after 2", 32'(in_ready), 32'd0);
        op_a = 32'h7F800000; op_b = 32'h3F800000; op_ctrl = 1'b0; add_ans = 32'h7F800000;
        @(posedge clk); #1;
        check("bp in_ready held", 32'(in_ready), 32'd0);
        check("bp head held", out_res, want[0]);
        check("bp valid held", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (out_valid) got.push_back(out_res);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        check("bp count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp order%0d", i), (i < got.size()) ? got[i] : 32'hDEADBEEF, want[i]);
        end

        // Async reset with two buffered entries.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        op_a = 32'h3F800000; op_b = 32'h40000000; op_ctrl = 1'b0; add_ans = 32'h40400000;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("pre-rst full", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst out_res", out_res, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-rst in_ready", 32'(in_ready), 32'd1);
        check("post-rst out_valid", 32'(out_valid), 32'd0);
        check("post-rst out_flags", 32'(out_flags), 32'd0);
        run_one("post-rst txn", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 32'h40400000, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_add_post.md
# fp_add_post

Registered post-processing stage directly downstream of the combinational single-precision `Floating_adder`. It accepts operand requests on a valid/ready handshake and drives the adder's `enable`. It then takes the adder's `ans` in the same cycle, repairs the cases the adder does not handle (NaN, infinity, zero/denormal operands, exponent overflow, result sign on subtraction) and queues the final result and flags in a 2-entry output buffer.

## Interface
- `DEPTH`, 2: output buffer entries. Only 2 is supported.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `in_valid`  in  1  request present
- `in_ready`  out  1  request accepted when `in_valid && in_ready`
- `op_a`, `op_b`  in  32  IEEE-754 single operands, also wired to the adder's `a`/`b`
- `op_ctrl`  in  1  0 = add, 1 = subtract; also wired to the adder's `ctrl`
- `add_en`  out  1  drives the adder's `enable`
- `add_ans`  in  32  adder's `ans`, sampled on the accept cycle
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer takes the result when `out_valid && out_ready`
- `out_res`  out  32  final result
- `out_flags`  out  3  {invalid, overflow, zero}

## Operation
- Effective b: `bs = op_b[31] ^ op_ctrl`. Class per operand: NaN (exp FF, mant≠0), Inf (exp FF, mant 0), Zero (exp 00; denormals flush to zero), Normal.
- Result priority (first match wins):
  1. Any NaN -> `0x7FC00000`, invalid = 1.
  2. Inf and Inf with `op_a[31] != bs` -> `0x7FC00000`, invalid = 1.
  3. One Inf -> that Inf. Sign is `op_a[31]` or `bs` as applicable.
  4. Both Zero -> `{op_a[31] & bs, 31'b0}`.
  5. a Zero -> `{bs, op_b[30:0]}`. b Zero -> `op_a`, with denormal magnitude flushed to 0.
  6. `add_ans[30:23] == FF` -> `{sign, 0x7F800000[30:0]}`, overflow = 1.
  7. `add_ans[30:0] == 0` -> `0x00000000`. This covers both exact cancellation and adder flush-to-zero.
  8. Otherwise -> `{sign, add_ans[30:0]}`. `sign = op_a[31]` if `op_a[30:0] > op_b[30:0]`, else `bs`; ties resolve to `bs`.
- The zero flag is set whenever `out_res[30:0] == 0`.
- `add_en = in_valid`. It is a don't-care when no request is present.
- Buffer:
  - 2-entry FIFO with a 2-bit count (0..2).
  - `in_ready = (count != 2)`. A pop in the same cycle does not free space for a push.
  - Push and pop in the same cycle leave the count unchanged.
  - Strict FIFO order.

## Timing
- Latency: a request accepted at edge N makes its result visible at `out_valid` after edge N.
- Throughput is 1/cycle while `out_ready = 1`.
- `out_res` and `out_flags` hold steady while `out_valid && !out_ready`.
- Reset values:
  - count 0, `out_valid` 0, `out_res` 0, `out_flags` 0, `in_ready` 1 after reset deasserts.
  - Asserting `rst_n` low mid-stream drops all buffered results immediately and asynchronously.
- Full: an `in_valid` held while `in_ready = 0` is not accepted. The requester must hold its operands stable.
- Empty: `out_ready` has no effect.

## Structure
- Package `fpu_pkg`:
  - `EXP_MAX = 8'hFF`, `QNAN = 32'h7FC00000`, `FLAG_INVALID = 2`, `FLAG_OVF = 1`, `FLAG_ZERO = 0`.
  - Operand class enum {ZERO, NORMAL, INF, NAN}.
  - Field-extract helpers.
- Sub-module `fp_res_fifo`: 35-bit-wide, 2-deep FIFO with count, push/pop and full/empty.
- The special-case fix-up logic is combinational in `fp_add_post` and feeds the FIFO push data.

## Test plan
- `0x3F800000 + 0x40000000`, ctrl 0 -> `0x40400000`, flags 000, `out_valid` one cycle after accept.
- `0x3F800000 - 0x40000000`, ctrl 1 (adder returns sign +) -> `0xBF800000`, flags 000.
- `0x3F800000 - 0x3F800000` -> `0x00000000`, flags 001. Separately, `0x7F800000 - 0x7F800000` -> `0x7FC00000`, flags 100. Separately, `0x7FC00001 + 0x3F800000` -> `0x7FC00000`, flags 100.
- `0x7F7FFFFF + 0x7F7FFFFF` (adder emits exp FF with nonzero mantissa) -> `0x7F800000`, flags 010. Separately, `0x00000000 - 0x40000000` -> `0xC0000000`, flags 000.
- Backpressure: `out_ready = 0`, three back-to-back requests -> `in_ready` drops after the 2nd accept and the 3rd is held. Raise `out_ready` -> results emerge in order 1, 2, 3, with no duplicates or loss.
- Assert `rst_n` low with 2 entries buffered -> `out_valid` falls to 0 immediately. After release, count is 0 and `in_ready` is 1.
